aes128_wb_ctrl: RTL and testbench

Wishbone-slave controller that sequences the `aes128` encryption core. It holds the 128-bit key and plaintext in software-visible registers and drives them stable onto the core. On a start command it counts the core's fixed pipeline latency, then captures the 128-bit ciphertext into readback registers and raises done/IRQ. It sits between the management SoC Wishbone port and the core inside `user_project_wrapper`.

---
 rtl/aes128_ctrl_pkg.sv | 40 ++++
 rtl/aes128_wb_regs.sv | 114 +++++++++++
 rtl/aes128_wb_ctrl.sv | 114 +++++++++++
 tb/tb_aes128_wb_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_ctrl_pkg.sv
// aes128_ctrl_pkg
// Shared definitions for the aes128 Wishbone controller:
//   - register byte offsets relative to the block base
//   - CTRL / STATUS bit indices
//   - controller FSM state encoding
//   - byte-enable merge helper used by the register file
package aes128_ctrl_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_KEY0   = 8'h10;
    localparam logic [7:0] OFF_PT0    = 8'h20;
    localparam logic [7:0] OFF_CT0    = 8'h30;

    localparam int unsigned CTRL_START_BIT   = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 1;

    localparam int unsigned STATUS_BUSY_BIT  = 0;
    localparam int unsigned STATUS_DONE_BIT  = 1;
    localparam int unsigned STATUS_ERR_BIT   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

    // Replace only the bytes whose enable is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = cur;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = wdat[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes128_wb_regs.sv
// aes128_wb_regs
// Wishbone slave front end for the aes128 controller: address decode,
// single-cycle ack, byte-enable register writes and the readback mux.
// Holds KEY0..3, PT0..3, STATUS.ERR and (optionally) CTRL.IRQ_EN.
// Optional feature macro: AES128_CTRL_IRQ_EN (adds the irq_en output).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wbs_*             Wishbone slave request / response
//   busy, done, ct    controller state and captured ciphertext for readback
//   key, pt           software-visible key / plaintext registers
//   start             accepted START pulse (only when not busy)
//   done_clr          STATUS.DONE write-1-to-clear pulse
//   irq_en            CTRL.IRQ_EN (only with AES128_CTRL_IRQ_EN)
module aes128_wb_regs
    import aes128_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic             busy,
    input  logic             done,
    input  logic [3:0][31:0] ct,
    output logic [3:0][31:0] key,
    output logic [3:0][31:0] pt,
    output logic             start,
    output logic             done_clr
`ifdef AES128_CTRL_IRQ_EN
    ,
    output logic             irq_en
`endif
);

    logic [7:0]  off;
    logic [1:0]  widx;
    logic        req, wr;
    logic        is_key, is_pt, is_ct, is_ctrl, is_status;
    logic        ctrl_wr, status_wr;
    logic        err, err_set, err_clr;
    logic [31:0] rdata;

    assign off  = wbs_adr_i[7:0];
    assign widx = off[3:2];

    // ~wbs_ack_o keeps a held request from being accepted twice.
    assign req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
    assign wr  = req & wbs_we_i;

    assign is_ctrl   = (off == OFF_CTRL);
    assign is_status = (off == OFF_STATUS);
    assign is_key    = (off[7:4] == OFF_KEY0[7:4]) && (off[1:0] == 2'b00);
    assign is_pt     = (off[7:4] == OFF_PT0[7:4])  && (off[1:0] == 2'b00);
    assign is_ct     = (off[7:4] == OFF_CT0[7:4])  && (off[1:0] == 2'b00);

    assign ctrl_wr   = wr & is_ctrl   & wbs_sel_i[0];
    assign status_wr = wr & is_status & wbs_sel_i[0];

    assign start    = ctrl_wr & wbs_dat_i[CTRL_START_BIT] & ~busy;
    assign done_clr = status_wr & wbs_dat_i[STATUS_DONE_BIT];
    assign err_clr  = status_wr & wbs_dat_i[STATUS_ERR_BIT];
    assign err_set  = busy & ((ctrl_wr & wbs_dat_i[CTRL_START_BIT]) | (wr & (is_key | is_pt)));

    always_comb begin
        rdata = '0;
        if (is_ctrl) begin
`ifdef AES128_CTRL_IRQ_EN
            rdata[CTRL_IRQ_EN_BIT] = irq_en;
`endif
        end else if (is_status) begin
            rdata[STATUS_BUSY_BIT] = busy;
            rdata[STATUS_DONE_BIT] = done;
            rdata[STATUS_ERR_BIT]  = err;
        end else if (is_key) begin
            rdata = key[widx];
        end else if (is_pt) begin
            rdata = pt[widx];
        end else if (is_ct) begin
            rdata = ct[widx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            key       <= '0;
            pt        <= '0;
            err       <= 1'b0;
`ifdef AES128_CTRL_IRQ_EN
            irq_en    <= 1'b0;
`endif
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req & ~wbs_we_i) ? rdata : '0;
            if (wr && !busy && is_key) key[widx] <= merge_bytes(key[widx], wbs_dat_i, wbs_sel_i);
            if (wr && !busy && is_pt)  pt[widx]  <= merge_bytes(pt[widx], wbs_dat_i, wbs_sel_i);
            // A new error wins over a clear landing on the same edge.
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
`ifdef AES128_CTRL_IRQ_EN
            if (ctrl_wr) irq_en <= wbs_dat_i[CTRL_IRQ_EN_BIT];
`endif
        end
    end

endmodule

// File: rtl/aes128_wb_ctrl.sv
// aes128_wb_ctrl
// Wishbone-controlled sequencer for the aes128 core. Key and plaintext
// registers drive the core continuously; a START command counts the core's
// fixed latency, then the ciphertext is captured and DONE is raised.
// Optional feature macro: AES128_CTRL_IRQ_EN (adds irq = DONE & IRQ_EN).
// Ports:
//   clk, rst_n      clock (shared with aes128), async active-low reset
//   wbs_*           Wishbone slave port from the management SoC
//   aes_key         to core key input
//   aes_state       to core state (plaintext) input
//   aes_out         from core output
//   irq             level interrupt (only with AES128_CTRL_IRQ_EN)
module aes128_wb_ctrl
    import aes128_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned AES_LATENCY = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic [127:0]  aes_key,
    output logic [127:0]  aes_state,
    input  logic [127:0]  aes_out
`ifdef AES128_CTRL_IRQ_EN
    ,
    output logic          irq
`endif
);

    localparam logic [7:0] LAT_INIT = 8'(AES_LATENCY);

    ctrl_state_e      state;
    logic [7:0]       cnt;
    logic             done_q;
    logic [3:0][31:0] ct_w;
    logic             busy, start, done_clr;
`ifdef AES128_CTRL_IRQ_EN
    logic             irq_en;
`endif

    assign busy = (state == RUN);

    aes128_wb_regs #(
        .BASE_ADDR (BASE_ADDR)
    ) u_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .busy      (busy),
        .done      (done_q),
        .ct        (ct_w),
        .key       (aes_key),
        .pt        (aes_state),
        .start     (start),
        .done_clr  (done_clr)
`ifdef AES128_CTRL_IRQ_EN
        ,
        .irq_en    (irq_en)
`endif
    );

`ifdef AES128_CTRL_IRQ_EN
    assign irq = done_q & irq_en;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
            ct_w   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RUN;
                        cnt    <= LAT_INIT;
                        done_q <= 1'b0;
                    end else if (done_clr) begin
                        done_q <= 1'b0;
                    end
                end
                RUN: begin
                    cnt <= cnt - 8'd1;
                    // Capture takes priority over a DONE clear on the same edge.
                    if (cnt == 8'd1) begin
                        ct_w   <= aes_out;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (done_clr) begin
                        done_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_wb_ctrl.sv
module tb_aes128_wb_ctrl;

    localparam logic [31:0]  BASE = 32'h3000_0000;
    localparam int unsigned  LAT  = 21;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]   wbs_sel_i = '0;
    logic [31:0]  wbs_adr_i = '0, wbs_dat_i = '0;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic [127:0] aes_key, aes_state, aes_out;
`ifdef AES128_CTRL_IRQ_EN
    logic         irq;
`endif

    aes128_wb_ctrl #(
        .BASE_ADDR   (BASE),
        .AES_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .aes_key   (aes_key),
        .aes_state (aes_state),
        .aes_out   (aes_out)
`ifdef AES128_CTRL_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    initial forever #5 clk = ~clk;

    int unsigned cyc_n = 0;
    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    // Stand-in for the aes128 core: a LAT-deep pipeline of a keyed mix that
    // yields the FIPS-197 ciphertext for the known-answer inputs.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == KAT_KEY && p == KAT_PT) return KAT_CT;
        return ((k ^ {p[63:0], p[127:64]}) + {p[31:0], k[127:32]}) ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    logic [127:0] pipe [LAT] = '{default: '0};
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= core_fn(aes_key, aes_state);
    end
    assign aes_out = pipe[LAT-1];

    // ---------------- reference model ----------------
    logic [3:0][31:0] m_key, m_pt, m_ct;
    logic [127:0]     m_next_ct;
    bit               m_irq_en, m_done, m_err, m_active;
    int unsigned      m_start;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  off;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_key = '0; m_pt = '0; m_ct = '0; m_next_ct = '0;
        m_irq_en = 0; m_done = 0; m_err = 0; m_active = 0; m_start = 0;
    endtask

    // Bring the model up to the state that holds just after edge t.
    function automatic void settle(input int unsigned t);
        if (m_active && m_start + LAT <= t) begin
            m_ct     = m_next_ct;
            m_done   = 1;
            m_active = 0;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] off);
        logic [31:0] r;
        r = '0;
        if (off == 8'h00) r[1] = m_irq_en;
        else if (off == 8'h04) r = {29'b0, m_err, m_done, m_active};
        else if (off[1:0] == 2'b00 && off[7:4] == 4'h1) r = m_key[off[3:2]];
        else if (off[1:0] == 2'b00 && off[7:4] == 4'h2) r = m_pt[off[3:2]];
        else if (off[1:0] == 2'b00 && off[7:4] == 4'h3) r = m_ct[off[3:2]];
        return r;
    endfunction

    function automatic void model_write(input int unsigned t, input logic [7:0] off,
                                        input logic [31:0] d, input logic [3:0] sel);
        bit busy;
        busy = m_active;
        if (off == 8'h00) begin
            if (sel[0]) begin
`ifdef AES128_CTRL_IRQ_EN
                m_irq_en = d[1];
`endif
                if (d[0]) begin
                    if (busy) m_err = 1;
                    else begin
                        m_done = 0; m_active = 1; m_start = t;
                        m_next_ct = core_fn(m_key, m_pt);
                    end
                end
            end
        end else if (off == 8'h04) begin
            if (sel[0] && d[1]) m_done = 0;
            if (sel[0] && d[2]) m_err = 0;
        end else if (off[1:0] == 2'b00 && (off[7:4] == 4'h1 || off[7:4] == 4'h2)) begin
            if (busy) m_err = 1;
            else begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) begin
                        if (off[7:4] == 4'h1) m_key[off[3:2]][8*i +: 8] = d[8*i +: 8];
                        else                  m_pt[off[3:2]][8*i +: 8]  = d[8*i +: 8];
                    end
                end
            end
        end
    endfunction

    // ---------------- monitor ----------------
    initial forever begin
        @(posedge clk);
        #1;
        if (wbs_ack_o && !wbs_we_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_read_ack: got data %h with no read outstanding", wbs_dat_o);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("read_off_%02h", mon_e.off), {96'b0, wbs_dat_o}, {96'b0, mon_e.data});
            end
        end
    end

    // ---------------- bus master ----------------
    task automatic bus(input bit we, input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
        int unsigned t;
        int waited;
        exp_t e;
        @(negedge clk);
        t = cyc_n + 1;
        settle(t - 1);
        if (we) model_write(t, off, d, sel);
        else begin
            e.off = off; e.data = model_read(off);
            exp_q.push_back(e);
        end
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
        wbs_adr_i = BASE | {24'b0, off}; wbs_dat_i = d; wbs_sel_i = sel;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!wbs_ack_o && waited < 4);
        if (!wbs_ack_o) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_timeout off=%02h: got ack 0 required ack 1", off);
            if (!we) void'(exp_q.pop_back());
        end
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = '0; wbs_dat_i = '0;
`ifdef AES128_CTRL_IRQ_EN
        settle(t);
        check("irq", {127'b0, irq}, {127'b0, m_done & m_irq_en});
`endif
    endtask

    task automatic bus_at(input int unsigned t, input bit we, input logic [7:0] off,
                          input logic [31:0] d, input logic [3:0] sel);
        int g;
        g = 0;
        while (cyc_n + 2 < t && g < 1000) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (cyc_n + 2 != t) begin
            n_bad++;
            $display("FAIL schedule: got edge %0d required edge %0d", cyc_n + 2, t);
        end
        bus(we, off, d, sel);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic poll_done();
        int g;
        g = 0;
        while (m_active && g < 60) begin
            bus(0, 8'h04, '0, '0);
            idle($urandom_range(0, 2));
            g++;
        end
        if (m_active) begin
            n_cmp++; n_bad++;
            $display("FAIL poll_timeout: got busy after %0d polls required done", g);
        end
    endtask

    task automatic read_ct();
        for (int i = 0; i < 4; i++) bus(0, 8'h30 + 8'(4*i), '0, '0);
    endtask

    logic [127:0] v;
    logic [7:0]   o;
    int unsigned  e0;

    initial begin
        model_reset();
        // Reset values
        idle(3);
        #1;
        check("rst_ack", {127'b0, wbs_ack_o}, 128'd0);
        check("rst_dat", {96'b0, wbs_dat_o}, 128'd0);
        check("rst_key", aes_key, 128'd0);
        check("rst_state", aes_state, 128'd0);
`ifdef AES128_CTRL_IRQ_EN
        check("rst_irq", {127'b0, irq}, 128'd0);
`endif
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 18; i++) bus(0, 8'(4*i), '0, '0);

        // Known-answer run with exact BUSY boundary
        v = KAT_KEY;
        for (int i = 0; i < 4; i++) bus(1, 8'h10 + 8'(4*i), v[32*i +: 32], 4'hF);
        v = KAT_PT;
        for (int i = 0; i < 4; i++) bus(1, 8'h20 + 8'(4*i), v[32*i +: 32], 4'hF);
        check("aes_key_port", aes_key, KAT_KEY);
        check("aes_state_port", aes_state, KAT_PT);
        bus(1, 8'h00, 32'h1, 4'hF);
        e0 = m_start;
        bus_at(e0 + LAT, 0, 8'h04, '0, '0);     // last busy cycle
        bus(0, 8'h30, '0, '0);                  // new result now
        read_ct();
        bus(0, 8'h04, '0, '0);

        // Second run: first non-busy cycle, CT during RUN keeps old value
        bus(1, 8'h00, 32'h1, 4'hF);
        e0 = m_start;
        bus(0, 8'h3C, '0, '0);
        bus_at(e0 + LAT + 1, 0, 8'h04, '0, '0);

        // Byte enables
        bus(1, 8'h10, 32'hFFFF_FFFF, 4'hF);
        bus(1, 8'h10, 32'h0000_00AA, 4'h1);
        bus(0, 8'h10, '0, '0);
        for (int i = 0; i < 8; i++) begin
            o = (i < 4) ? 8'h10 + 8'(4*i) : 8'h20 + 8'(4*(i-4));
            bus(1, o, $urandom, 4'($urandom_range(0, 15)));
            bus(0, o, '0, '0);
        end

        // Writes and START while busy
        bus(1, 8'h00, 32'h1, 4'hF);
        bus(1, 8'h24, $urandom, 4'hF);
        bus(1, 8'h00, 32'h1, 4'hF);
        bus(0, 8'h24, '0, '0);
        bus(0, 8'h04, '0, '0);
        poll_done();
        read_ct();
        bus(1, 8'h04, 32'h4, 4'hF);
        bus(0, 8'h04, '0, '0);

        // DONE clear landing on the capture edge
        bus(1, 8'h00, 32'h1, 4'hF);
        e0 = m_start;
        bus_at(e0 + LAT, 1, 8'h04, 32'h2, 4'hF);
        bus(0, 8'h04, '0, '0);
        bus(1, 8'h04, 32'h2, 4'hF);
        bus(0, 8'h04, '0, '0);

        // IRQ enable (reads back 0 when the feature is absent)
        bus(1, 8'h00, 32'h2, 4'hF);
        bus(0, 8'h00, '0, '0);
        bus(1, 8'h00, 32'h3, 4'hF);
        poll_done();
        bus(1, 8'h04, 32'h2, 4'hF);
        bus(0, 8'h04, '0, '0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0: bus(0, 8'(4*$urandom_range(0, 17)), '0, '0);
                1: bus(0, 8'($urandom_range(0, 255)), '0, '0);
                2: bus(1, 8'h10 + 8'(4*$urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
                3: bus(1, 8'h00, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
                4: bus(1, 8'h04, 32'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
                default: idle($urandom_range(1, 8));
            endcase
        end
        poll_done();
        read_ct();

        // Reset in the middle of RUN
        bus(1, 8'h00, 32'h1, 4'hF);
        e0 = m_start;
        while (cyc_n < e0 + 10) @(negedge clk);
        rst_n = 0;
        model_reset();
        #1;
        check("midrun_rst_ack", {127'b0, wbs_ack_o}, 128'd0);
        check("midrun_rst_key", aes_key, 128'd0);
`ifdef AES128_CTRL_IRQ_EN
        check("midrun_rst_irq", {127'b0, irq}, 128'd0);
`endif
        idle(2);
        rst_n = 1;
        bus(0, 8'h04, '0, '0);
        idle(LAT + 5);
        bus(0, 8'h04, '0, '0);
        read_ct();

        idle(3);
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL pending_reads: got %0d outstanding required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion required completion");
        $fatal(1, "watchdog");
    end

endmodule
